// File: rtl/tmr_elink_voter_mon_pkg.sv
// Shared state encoding and helpers for the TMR e-link voter and its per-copy monitors.
package tmr_elink_voter_mon_pkg;

  localparam int unsigned ST_W = 2;

  localparam logic [ST_W-1:0] ST_OK      = 2'd0;
  localparam logic [ST_W-1:0] ST_SUSPECT = 2'd1;
  localparam logic [ST_W-1:0] ST_FAULTY  = 2'd2;

  function automatic logic [1:0] fault_count(input logic [2:0] f);
    return {1'b0, f[0]} + {1'b0, f[1]} + {1'b0, f[2]};
  endfunction

endpackage

// File: rtl/tmr_elink_voter_mon_copy_monitor.sv
// Per-copy health monitor: OK/SUSPECT/FAULTY FSM with run counter and saturating error counter.
module tmr_copy_monitor
  import tmr_elink_voter_mon_pkg::*;
#(
  parameter int unsigned FAULT_THRESH = 4,
  parameter int unsigned ERR_CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_i,
  input  logic                 mism_i,
  input  logic                 clr_i,
  output logic [ST_W-1:0]      state_o,
  output logic [ERR_CNT_W-1:0] err_cnt_o
);

  localparam int unsigned RUN_W = $clog2(FAULT_THRESH + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(FAULT_THRESH);

  logic [ST_W-1:0]      state_q, state_d;
  logic [RUN_W-1:0]     run_q, run_d, run_inc;
  logic [ERR_CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    state_d = state_q;
    run_d   = run_q;
    run_inc = run_q + RUN_W'(1);
    if (valid_i) begin
      case (state_q)
        ST_OK: begin
          if (mism_i) begin
            state_d = ST_SUSPECT;
            run_d   = RUN_W'(1);
          end
        end
        ST_SUSPECT: begin
          if (!mism_i) begin
            state_d = ST_OK;
            run_d   = '0;
          end else if (run_inc == RUN_MAX) begin
            state_d = ST_FAULTY;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        ST_FAULTY: begin
          if (mism_i) begin
            run_d = '0;
          end else if (run_inc == RUN_MAX) begin
            state_d = ST_OK;
            run_d   = '0;
          end else begin
            run_d = run_inc;
          end
        end
        default: begin
          state_d = ST_OK;
          run_d   = '0;
        end
      endcase
    end
  end

  // Clear takes priority over a same-cycle increment; counter sticks at all-ones.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (valid_i && mism_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + ERR_CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_OK;
      run_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      run_q   <= run_d;
      cnt_q   <= cnt_d;
    end
  end

  assign state_o   = state_q;
  assign err_cnt_o = cnt_q;

endmodule

// File: rtl/tmr_elink_voter_mon.sv
// Triple-modular-redundancy voter for e-link trigger words with per-copy health monitoring.
module tmr_elink_voter_mon
  import tmr_elink_voter_mon_pkg::*;
#(
  parameter int unsigned WIDTH        = 12,
  parameter int unsigned LANES        = 1,
  parameter int unsigned ERR_CNT_W    = 16,
  parameter int unsigned FAULT_THRESH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  input  logic [LANES*WIDTH-1:0] data_in1,
  input  logic [LANES*WIDTH-1:0] data_in2,
  input  logic [LANES*WIDTH-1:0] data_in3,
  input  logic                   cnt_clr,
  output logic [LANES*WIDTH-1:0] voted,
  output logic                   out_valid,
  output logic [2:0]             mismatch,
  output logic                   multi_err,
  output logic                   degraded,
  output logic [ERR_CNT_W-1:0]   err_cnt1,
  output logic [ERR_CNT_W-1:0]   err_cnt2,
  output logic [ERR_CNT_W-1:0]   err_cnt3,
  output logic [5:0]             copy_state,
  output logic [2:0]             fault
);

  localparam int unsigned DW = LANES * WIDTH;

  logic [DW-1:0]   maj, sel;
  logic [2:0]      mism, fault_now;
  logic            multi, degr_sel;
  logic [ST_W-1:0] st1, st2, st3;

  logic [DW-1:0] voted_q, voted_d;
  logic          ovalid_q;
  logic [2:0]    mism_q, mism_d;
  logic          multi_q, multi_d;
  logic          degr_q, degr_d;

  assign maj = (data_in1 & data_in2) | (data_in1 & data_in3) | (data_in2 & data_in3);

  assign mism[0] = |(data_in1 ^ maj);
  assign mism[1] = |(data_in2 ^ maj);
  assign mism[2] = |(data_in3 ^ maj);

  always_comb begin
    multi = 1'b0;
    for (int unsigned l = 0; l < LANES; l++) begin
      if ((data_in1[l*WIDTH +: WIDTH] != data_in2[l*WIDTH +: WIDTH]) &&
          (data_in1[l*WIDTH +: WIDTH] != data_in3[l*WIDTH +: WIDTH]) &&
          (data_in2[l*WIDTH +: WIDTH] != data_in3[l*WIDTH +: WIDTH])) begin
        multi = 1'b1;
      end
    end
  end

  // Degraded selection looks at the FSM state held before this sample.
  assign fault_now = {st3 == ST_FAULTY, st2 == ST_FAULTY, st1 == ST_FAULTY};
  assign degr_sel  = (fault_count(fault_now) == 2'd2);

  always_comb begin
    case (fault_now)
      3'b011:  sel = data_in3;
      3'b101:  sel = data_in2;
      3'b110:  sel = data_in1;
      default: sel = maj;
    endcase
  end

  always_comb begin
    voted_d = voted_q;
    mism_d  = '0;
    multi_d = 1'b0;
    degr_d  = 1'b0;
    if (in_valid) begin
      voted_d = sel;
      mism_d  = mism;
      multi_d = multi;
      degr_d  = degr_sel;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      voted_q  <= '0;
      ovalid_q <= 1'b0;
      mism_q   <= '0;
      multi_q  <= 1'b0;
      degr_q   <= 1'b0;
    end else begin
      voted_q  <= voted_d;
      ovalid_q <= in_valid;
      mism_q   <= mism_d;
      multi_q  <= multi_d;
      degr_q   <= degr_d;
    end
  end

  tmr_copy_monitor #(.FAULT_THRESH(FAULT_THRESH), .ERR_CNT_W(ERR_CNT_W)) u_mon1 (
    .clk(clk), .rst(rst), .valid_i(in_valid), .mism_i(mism[0]), .clr_i(cnt_clr),
    .state_o(st1), .err_cnt_o(err_cnt1)
  );

  tmr_copy_monitor #(.FAULT_THRESH(FAULT_THRESH), .ERR_CNT_W(ERR_CNT_W)) u_mon2 (
    .clk(clk), .rst(rst), .valid_i(in_valid), .mism_i(mism[1]), .clr_i(cnt_clr),
    .state_o(st2), .err_cnt_o(err_cnt2)
  );

  tmr_copy_monitor #(.FAULT_THRESH(FAULT_THRESH), .ERR_CNT_W(ERR_CNT_W)) u_mon3 (
    .clk(clk), .rst(rst), .valid_i(in_valid), .mism_i(mism[2]), .clr_i(cnt_clr),
    .state_o(st3), .err_cnt_o(err_cnt3)
  );

  assign voted      = voted_q;
  assign out_valid  = ovalid_q;
  assign mismatch   = mism_q;
  assign multi_err  = multi_q;
  assign degraded   = degr_q;
  assign copy_state = {st3, st2, st1};
  assign fault      = fault_now;

endmodule

// File: tb/tb_tmr_elink_voter_mon.sv
// Self-checking bench for tmr_elink_voter_mon: directed table, corner sequences and randomized model checks.
module tb_tmr_elink_voter_mon;

  localparam int W  = 12;
  localparam int L  = 2;
  localparam int CW = 4;
  localparam int TH = 4;
  localparam int DW = W * L;
  localparam int CMAX = (1 << CW) - 1;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic cnt_clr = 1'b0;
  logic [DW-1:0] data_in1 = '0, data_in2 = '0, data_in3 = '0;
  logic [DW-1:0] voted;
  logic out_valid, multi_err, degraded;
  logic [2:0] mismatch, fault;
  logic [CW-1:0] err_cnt1, err_cnt2, err_cnt3;
  logic [5:0] copy_state;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  tmr_elink_voter_mon #(.WIDTH(W), .LANES(L), .ERR_CNT_W(CW), .FAULT_THRESH(TH)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid),
    .data_in1(data_in1), .data_in2(data_in2), .data_in3(data_in3),
    .cnt_clr(cnt_clr), .voted(voted), .out_valid(out_valid), .mismatch(mismatch),
    .multi_err(multi_err), .degraded(degraded),
    .err_cnt1(err_cnt1), .err_cnt2(err_cnt2), .err_cnt3(err_cnt3),
    .copy_state(copy_state), .fault(fault)
  );

  // Reference model: copy health kept as small integers, votes counted per bit.
  int m_st[3];
  int m_run[3];
  int m_cnt[3];
  logic [DW-1:0] m_voted;
  logic [2:0] m_mis;
  bit m_ov, m_multi, m_deg;

  task automatic model_reset();
    for (int k = 0; k < 3; k++) begin
      m_st[k] = 0; m_run[k] = 0; m_cnt[k] = 0;
    end
    m_voted = '0; m_mis = '0; m_ov = 0; m_multi = 0; m_deg = 0;
  endtask

  function automatic logic [DW-1:0] majority(input logic [DW-1:0] a, b, c);
    logic [DW-1:0] r;
    int ones;
    for (int i = 0; i < DW; i++) begin
      ones = int'(a[i]) + int'(b[i]) + int'(c[i]);
      r[i] = (ones >= 2);
    end
    return r;
  endfunction

  task automatic model_step(input bit v, input logic [DW-1:0] a, b, c, input bit clr);
    logic [DW-1:0] d[3];
    logic [DW-1:0] mj;
    logic [W-1:0] la, lb, lc;
    int nf;
    d[0] = a; d[1] = b; d[2] = c;
    mj = majority(a, b, c);
    nf = 0;
    for (int k = 0; k < 3; k++) if (m_st[k] == 2) nf++;
    m_ov = v;
    if (v) begin
      if (nf == 2) begin
        for (int k = 0; k < 3; k++) if (m_st[k] != 2) m_voted = d[k];
        m_deg = 1;
      end else begin
        m_voted = mj;
        m_deg = 0;
      end
      for (int k = 0; k < 3; k++) m_mis[k] = (d[k] != mj);
      m_multi = 0;
      for (int l = 0; l < L; l++) begin
        la = a[l*W +: W]; lb = b[l*W +: W]; lc = c[l*W +: W];
        if (la != lb && la != lc && lb != lc) m_multi = 1;
      end
    end else begin
      m_mis = '0; m_multi = 0; m_deg = 0;
    end
    for (int k = 0; k < 3; k++) begin
      if (clr) m_cnt[k] = 0;
      else if (v && m_mis[k]) m_cnt[k] = (m_cnt[k] < CMAX) ? m_cnt[k] + 1 : CMAX;
      if (v) begin
        case (m_st[k])
          0: if (m_mis[k]) begin m_st[k] = 1; m_run[k] = 1; end
          1: if (m_mis[k]) begin
               m_run[k]++;
               if (m_run[k] == TH) begin m_st[k] = 2; m_run[k] = 0; end
             end else begin
               m_st[k] = 0; m_run[k] = 0;
             end
          default: if (m_mis[k]) m_run[k] = 0;
             else begin
               m_run[k]++;
               if (m_run[k] == TH) begin m_st[k] = 0; m_run[k] = 0; end
             end
        endcase
      end
    end
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check_model(input string tag);
    logic [5:0] est;
    logic [2:0] ef;
    for (int k = 0; k < 3; k++) begin
      est[2*k +: 2] = 2'(m_st[k]);
      ef[k] = (m_st[k] == 2);
    end
    chk({tag, ".voted"}, 64'(voted), 64'(m_voted));
    chk({tag, ".out_valid"}, 64'(out_valid), 64'(m_ov));
    chk({tag, ".mismatch"}, 64'(mismatch), 64'(m_mis));
    chk({tag, ".multi_err"}, 64'(multi_err), 64'(m_multi));
    chk({tag, ".degraded"}, 64'(degraded), 64'(m_deg));
    chk({tag, ".err_cnt1"}, 64'(err_cnt1), 64'(m_cnt[0]));
    chk({tag, ".err_cnt2"}, 64'(err_cnt2), 64'(m_cnt[1]));
    chk({tag, ".err_cnt3"}, 64'(err_cnt3), 64'(m_cnt[2]));
    chk({tag, ".copy_state"}, 64'(copy_state), 64'(est));
    chk({tag, ".fault"}, 64'(fault), 64'(ef));
  endtask

  // Drive one sample, clock it in, advance the model, and land #1 after the edge.
  task automatic step(input bit v, input logic [DW-1:0] a, b, c, input bit clr);
    in_valid = v; data_in1 = a; data_in2 = b; data_in3 = c; cnt_clr = clr;
    @(posedge clk);
    model_step(v, a, b, c, clr);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0; cnt_clr = 1'b0;
    data_in1 = '0; data_in2 = '0; data_in3 = '0;
    model_reset();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
  endtask

  typedef struct {
    bit          v;
    logic [W-1:0] d1, d2, d3;
    bit          clr;
    logic [W-1:0] e_voted;
    logic [2:0]  e_mis;
    bit          e_multi;
    bit          e_deg;
    logic [5:0]  e_st;
    logic [2:0]  e_fault;
    logic [CW-1:0] e_cnt1;
  } vec_t;

  vec_t tbl[12];

  logic [DW-1:0] ones_w, zero_w, base, cp[3], msk;
  bit bad_mode[3];
  bit rv, rc;

  initial begin
    tbl[0]  = '{1, 12'hFFF, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3'b000, 0, 0, 6'b000000, 3'b000, 4'd0};
    tbl[1]  = '{1, 12'h000, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3'b001, 0, 0, 6'b000001, 3'b000, 4'd1};
    tbl[2]  = '{1, 12'h000, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3'b001, 0, 0, 6'b000001, 3'b000, 4'd2};
    tbl[3]  = '{1, 12'h000, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3'b001, 0, 0, 6'b000001, 3'b000, 4'd3};
    tbl[4]  = '{1, 12'h000, 12'hFFF, 12'hFFF, 0, 12'hFFF, 3'b001, 0, 0, 6'b000010, 3'b001, 4'd4};
    tbl[5]  = '{1, 12'hFFF, 12'h000, 12'h007, 0, 12'h007, 3'b011, 1, 0, 6'b000110, 3'b001, 4'd5};
    tbl[6]  = '{1, 12'hFFF, 12'h000, 12'h007, 0, 12'h007, 3'b011, 1, 0, 6'b000110, 3'b001, 4'd6};
    tbl[7]  = '{1, 12'hFFF, 12'h000, 12'h007, 0, 12'h007, 3'b011, 1, 0, 6'b000110, 3'b001, 4'd7};
    tbl[8]  = '{1, 12'hFFF, 12'h000, 12'h007, 0, 12'h007, 3'b011, 1, 0, 6'b001010, 3'b011, 4'd8};
    tbl[9]  = '{1, 12'h000, 12'h000, 12'h007, 0, 12'h007, 3'b100, 0, 1, 6'b011010, 3'b011, 4'd8};
    tbl[10] = '{0, 12'h000, 12'h000, 12'h000, 0, 12'h007, 3'b000, 0, 0, 6'b011010, 3'b011, 4'd8};
    tbl[11] = '{0, 12'h000, 12'h000, 12'h000, 1, 12'h007, 3'b000, 0, 0, 6'b011010, 3'b011, 4'd0};

    ones_w = '1;
    zero_w = '0;

    // Reset state
    do_reset();
    chk("rst.voted", 64'(voted), 64'h0);
    chk("rst.out_valid", 64'(out_valid), 64'h0);
    chk("rst.copy_state", 64'(copy_state), 64'h0);
    chk("rst.fault", 64'(fault), 64'h0);
    chk("rst.err_cnt1", 64'(err_cnt1), 64'h0);

    // Directed table: clean vote, copy1 faulting, copy2 faulting, degraded vote, hold, clear
    for (int i = 0; i < 12; i++) begin
      step(tbl[i].v, {tbl[i].d1, tbl[i].d1}, {tbl[i].d2, tbl[i].d2}, {tbl[i].d3, tbl[i].d3}, tbl[i].clr);
      chk($sformatf("tbl%0d.voted", i), 64'(voted), 64'({tbl[i].e_voted, tbl[i].e_voted}));
      chk($sformatf("tbl%0d.out_valid", i), 64'(out_valid), 64'(tbl[i].v));
      chk($sformatf("tbl%0d.mismatch", i), 64'(mismatch), 64'(tbl[i].e_mis));
      chk($sformatf("tbl%0d.multi_err", i), 64'(multi_err), 64'(tbl[i].e_multi));
      chk($sformatf("tbl%0d.degraded", i), 64'(degraded), 64'(tbl[i].e_deg));
      chk($sformatf("tbl%0d.copy_state", i), 64'(copy_state), 64'(tbl[i].e_st));
      chk($sformatf("tbl%0d.fault", i), 64'(fault), 64'(tbl[i].e_fault));
      chk($sformatf("tbl%0d.err_cnt1", i), 64'(err_cnt1), 64'(tbl[i].e_cnt1));
    end

    // Saturation of err_cnt1, then clear beating a simultaneous mismatch
    do_reset();
    for (int i = 0; i < 20; i++) begin
      step(1, zero_w, ones_w, ones_w, 0);
      check_model("sat");
    end
    chk("sat.err_cnt1_final", 64'(err_cnt1), 64'd15);
    chk("sat.copy1_faulty", 64'(copy_state[1:0]), 64'd2);
    step(1, zero_w, ones_w, ones_w, 1);
    chk("clr.err_cnt1", 64'(err_cnt1), 64'd0);
    check_model("clr");

    // Recovery: 3 clean, 1 bad, 3 clean stay FAULTY; 4th consecutive clean returns to OK
    for (int i = 0; i < 3; i++) begin
      step(1, ones_w, ones_w, ones_w, 0);
      chk("rec.clean3", 64'(copy_state[1:0]), 64'd2);
    end
    step(1, zero_w, ones_w, ones_w, 0);
    chk("rec.bad", 64'(copy_state[1:0]), 64'd2);
    for (int i = 0; i < 3; i++) begin
      step(1, ones_w, ones_w, ones_w, 0);
      chk("rec.clean_b", 64'(copy_state[1:0]), 64'd2);
    end
    step(1, ones_w, ones_w, ones_w, 0);
    chk("rec.ok_state", 64'(copy_state[1:0]), 64'd0);
    chk("rec.ok_fault", 64'(fault), 64'd0);
    check_model("rec");

    // Asynchronous reset mid-stream with toggling valid
    for (int i = 0; i < 8; i++) begin
      step(i[0], DW'($urandom), DW'($urandom), ((i % 3) == 0) ? zero_w : ones_w, 0);
      check_model("pre_rst");
    end
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    check_model("async_rst");
    @(posedge clk); #1;
    in_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step(0, DW'($urandom), DW'($urandom), DW'($urandom), 0);
      check_model("post_rst");
      chk("post_rst.voted0", 64'(voted), 64'h0);
    end

    // Randomized traffic with per-copy good/bad phases
    for (int k = 0; k < 3; k++) bad_mode[k] = 0;
    for (int n = 0; n < 800; n++) begin
      base = DW'($urandom);
      for (int k = 0; k < 3; k++) begin
        if ($urandom_range(0, 19) == 0) bad_mode[k] = !bad_mode[k];
        cp[k] = base;
        if (bad_mode[k] ? ($urandom_range(0, 9) != 0) : ($urandom_range(0, 29) == 0)) begin
          msk = DW'($urandom);
          if (msk == '0) msk = DW'(1);
          cp[k] = base ^ msk;
        end
      end
      rv = ($urandom_range(0, 99) < 85);
      rc = ($urandom_range(0, 49) == 0);
      step(rv, cp[0], cp[1], cp[2], rc);
      check_model("rand");
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not complete (errors=%0d)", errors);
    $fatal(1);
  end

endmodule
